pipe_subtractor_v: RTL and testbench
====================================

PIPE_SUBTRACTOR_V -- requirements
Module: pipe_subtractor_v

Interface
REQ-001 Parameter SLICE_W, default 8: width of each pipeline slice in bits.
REQ-002 Parameter N_SLICE, default 4: number of slices; operand width W = SLICE_W*N_SLICE (32 by default).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  synchronous clear of all pipeline contents.
REQ-006 stall  input  1  freeze; all pipeline registers hold their value.
REQ-007 req  input  1  marks x_0/x_1 as a valid operation this cycle.
REQ-008 x_0  input  W  minuend, sampled in the cycle req is presented.
REQ-009 x_1  input  W  subtrahend, sampled with x_0.
REQ-010 result  output  W  x_0 - x_1 modulo 2^W.
REQ-011 borrow  output  1  unsigned underflow flag (x_0 < x_1), aligned with result.
REQ-012 vld  output  1  result/borrow carry a completed operation.

Function
REQ-013 The block SHALL split the operands into N_SLICE slices of SLICE_W bits and compute slice k in pipeline stage k (k = 0..N_SLICE-1).
REQ-014 Slice k SHALL compute x_0[k] + ~x_1[k] + c_in; c_in SHALL be the constant 1 for slice 0 and the registered carry-out of slice k-1 for k > 0.
REQ-015 Operand slices for k > 0 SHALL be delayed by k register stages; the result of slice k SHALL be delayed by N_SLICE-1-k stages, so all slices align at the output.
REQ-016 borrow SHALL equal the inverted carry-out of the top slice, taken combinationally in the last stage and aligned with result.
REQ-017 Latency: an operation presented with req=1 at edge t SHALL appear with vld=1 at edge t+N_SLICE-1 (3 cycles by default) if no stall occurs.
REQ-018 Throughput: one operation per cycle; back-to-back req SHALL yield back-to-back vld.
REQ-019 The req flag SHALL travel through an N_SLICE-1 deep valid shift chain; vld is the final stage.
REQ-020 Data with req=0 SHALL still propagate; result/borrow are don't-care when vld=0 but SHALL be deterministic.
REQ-021 stall=1 SHALL hold every register, including valid chain and carry registers; inputs in that cycle SHALL be ignored; outputs SHALL hold.
REQ-022 flush=1 SHALL clear every register (data, carry, valid) to 0 at the next edge; vld SHALL be 0 on the following cycle.
REQ-023 flush SHALL take priority over stall; an operation issued with req in the flush cycle SHALL be discarded.
REQ-024 Wrap-around: results SHALL wrap modulo 2^W; no saturation.

Reset
REQ-025 reset=1 at a clock edge SHALL clear all registers; result=0, borrow=0 and vld=0 on the following cycle.
REQ-026 reset SHALL take priority over flush and stall.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations; no vld=1 SHALL appear until 3 cycles after the first req following reset release.

Verification
REQ-028 req=1, x_0=5, x_1=3 at edge t -> vld=1, result=0x00000002, borrow=0 at edge t+3; vld=0 at t+1 and t+2.
REQ-029 x_0=0x00000000, x_1=0x00000001 -> result=0xFFFFFFFF, borrow=1; x_0=0x00000100, x_1=0x00000001 -> result=0x000000FF, borrow=0 (borrow crosses slice boundary).
REQ-030 Four back-to-back reqs (10-1, 0x10000-1, 0x80000000-0x80000000, 1-2) -> four consecutive vld cycles with results 9, 0xFFFF, 0, 0xFFFFFFFF and borrows 0, 0, 0, 1.
REQ-031 req at edge t, stall=1 for 2 cycles from t+1 -> vld=1 with the correct result at edge t+5; outputs hold during the stall.
REQ-032 req at edge t, flush=1 at edge t+1 with stall=1 -> vld stays 0 and all registers are 0 afterwards; a new req at t+2 completes at t+5.
REQ-033 reset=1 with three operations in flight -> vld=0, result=0, borrow=0 from the next cycle; none of the earlier operations emerge.

Source files
------------

// File: rtl/pipe_subtractor_v.sv
// Pipelined W-bit subtractor: result = x_0 - x_1 (mod 2^W), borrow = x_0 < x_1.
// The operands are cut into N_SLICE slices of SLICE_W bits and slice k is
// resolved in pipeline stage k, with the carry rippling forward through registers.
// Latency is N_SLICE-1 cycles and a new operation can be accepted every cycle.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset; overrides flush and stall
//   flush  - synchronous clear of all pipeline contents; overrides stall
//   stall  - hold every register; inputs are ignored
//   req    - x_0/x_1 carry a valid operation this cycle
//   x_0    - minuend (W bits)
//   x_1    - subtrahend (W bits)
//   result - x_0 - x_1 modulo 2^W, forced to 0 while vld=0
//   borrow - unsigned underflow, forced to 0 while vld=0
//   vld    - result/borrow hold a completed operation
module pipe_subtractor_v #(
  parameter int unsigned SLICE_W = 8,
  parameter int unsigned N_SLICE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       req,
  input  logic [SLICE_W*N_SLICE-1:0] x_0,
  input  logic [SLICE_W*N_SLICE-1:0] x_1,
  output logic [SLICE_W*N_SLICE-1:0] result,
  output logic                       borrow,
  output logic                       vld
);

  localparam int unsigned W     = SLICE_W * N_SLICE;
  localparam int unsigned DEPTH = N_SLICE - 1;

  // Stage-to-stage carries and the aligned difference at the last stage.
  logic [N_SLICE-2:0] carry_c;
  logic [W-1:0]       diff_c;
  logic               top_cout_c;

  // Register clear (reset or flush) and advance enables shared by all stages.
  logic clr_c;
  logic adv_c;

  assign clr_c = reset | flush;
  assign adv_c = ~stall;

  for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
    logic [SLICE_W-1:0] a_c;
    logic [SLICE_W-1:0] b_c;
    logic               cin_c;
    logic [SLICE_W:0]   sum_c;

    // Operand source: raw inputs for slice 0, a k-deep delay line otherwise.
    if (k == 0) begin : g_src
      assign a_c   = x_0[k*SLICE_W +: SLICE_W];
      assign b_c   = x_1[k*SLICE_W +: SLICE_W];
      assign cin_c = 1'b1;
    end else begin : g_src
      logic [SLICE_W-1:0] a_q [k];
      logic [SLICE_W-1:0] b_q [k];

      always_ff @(posedge clk) begin
        if (clr_c) begin
          for (int i = 0; i < k; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else if (adv_c) begin
          a_q[0] <= x_0[k*SLICE_W +: SLICE_W];
          b_q[0] <= x_1[k*SLICE_W +: SLICE_W];
          for (int i = 1; i < k; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end

      assign a_c   = a_q[k-1];
      assign b_c   = b_q[k-1];
      assign cin_c = carry_c[k-1];
    end

    // Two's-complement subtraction slice: a + ~b + carry-in.
    assign sum_c = {1'b0, a_c} + {1'b0, ~b_c} + (SLICE_W+1)'(cin_c);

    if (k < N_SLICE - 1) begin : g_dst
      localparam int unsigned RD = N_SLICE - 1 - k;
      logic               carry_q;
      logic [SLICE_W-1:0] r_q [RD];

      // Carry out to the next slice plus an alignment delay for this result.
      always_ff @(posedge clk) begin
        if (clr_c) begin
          carry_q <= 1'b0;
          for (int i = 0; i < int'(RD); i++) begin
            r_q[i] <= '0;
          end
        end else if (adv_c) begin
          carry_q <= sum_c[SLICE_W];
          r_q[0]  <= sum_c[SLICE_W-1:0];
          for (int i = 1; i < int'(RD); i++) begin
            r_q[i] <= r_q[i-1];
          end
        end
      end

      assign carry_c[k]                  = carry_q;
      assign diff_c[k*SLICE_W +: SLICE_W] = r_q[RD-1];
    end else begin : g_dst
      // Top slice resolves combinationally off the last register stage.
      assign diff_c[k*SLICE_W +: SLICE_W] = sum_c[SLICE_W-1:0];
      assign top_cout_c                   = sum_c[SLICE_W];
    end
  end

  // Valid shift chain, one bit per register stage.
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  always_comb begin
    vld_d = vld_q;
    if (clr_c) begin
      vld_d = '0;
    end else if (adv_c) begin
      vld_d = {vld_q[DEPTH-2:0], req};
    end
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
  end

  // Outputs are zeroed when no operation is present so idle data never leaks out.
  assign vld    = vld_q[DEPTH-1];
  assign result = vld ? diff_c : '0;
  assign borrow = vld & ~top_cout_c;

endmodule

// File: tb/tb_pipe_subtractor_v.sv
// Self-checking bench for pipe_subtractor_v: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// delay-line model that computes the subtraction with plain arithmetic.
module tb_pipe_subtractor_v;

  localparam int unsigned SLICE_W = 8;
  localparam int unsigned N_SLICE = 4;
  localparam int unsigned W       = SLICE_W * N_SLICE;
  localparam int unsigned LAT     = N_SLICE - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         stall = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] x_0 = '0;
  logic [W-1:0] x_1 = '0;
  logic [W-1:0] result;
  logic         borrow;
  logic         vld;

  int n_total = 0;
  int n_pass  = 0;

  // Model: operations in flight, index 0 newest, LAT-1 at the output.
  logic         m_v [LAT];
  logic [W-1:0] m_a [LAT];
  logic [W-1:0] m_b [LAT];

  pipe_subtractor_v #(.SLICE_W(SLICE_W), .N_SLICE(N_SLICE)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .stall  (stall),
    .req    (req),
    .x_0    (x_0),
    .x_1    (x_1),
    .result (result),
    .borrow (borrow),
    .vld    (vld)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (reset || flush) begin
      for (int i = 0; i < int'(LAT); i++) begin
        m_v[i] = 1'b0; m_a[i] = '0; m_b[i] = '0;
      end
    end else if (!stall) begin
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_a[i] = m_a[i-1]; m_b[i] = m_b[i-1];
      end
      m_v[0] = req; m_a[0] = x_0; m_b[0] = x_1;
    end
  endtask

  task automatic compare(input string name, input logic ev, input logic [W-1:0] er,
                         input logic eb);
    n_total++;
    if (vld === ev && result === er && borrow === eb) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got vld=%0b result=%h borrow=%0b, expected vld=%0b result=%h borrow=%0b",
               name, $time, vld, result, borrow, ev, er, eb);
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check after it.
  task automatic step(input logic r, input logic f, input logic s, input logic q,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    logic         ev;
    logic [W-1:0] er;
    logic         eb;
    reset = r; flush = f; stall = s; req = q; x_0 = a; x_1 = b;
    @(posedge clk);
    model_edge();
    #1;
    ev = m_v[LAT-1];
    er = ev ? (m_a[LAT-1] - m_b[LAT-1]) : '0;
    eb = ev && (m_a[LAT-1] < m_b[LAT-1]);
    compare("model", ev, er, eb);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    step(1'b0, 1'b0, 1'b0, 1'b1, a, b);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = W'(32'h1) << $urandom_range(0, 31);
      default: v = W'($urandom());
    endcase
    return v;
  endfunction

  initial begin
    for (int i = 0; i < int'(LAT); i++) begin
      m_v[i] = 1'b0; m_a[i] = '0; m_b[i] = '0;
    end

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h5, 32'h3);
    compare("reset_state", 1'b0, 32'h0, 1'b0);

    // Latency of a single operation
    op(32'd5, 32'd3);
    compare("lat_t1", 1'b0, 32'h0, 1'b0);
    idle();
    compare("lat_t2", 1'b0, 32'h0, 1'b0);
    idle();
    compare("lat_t3", 1'b1, 32'h0000_0002, 1'b0);
    idle();
    compare("lat_after", 1'b0, 32'h0, 1'b0);

    // Borrow through every slice, and across one slice boundary
    op(32'h0000_0000, 32'h0000_0001);
    op(32'h0000_0100, 32'h0000_0001);
    idle();
    compare("borrow_all", 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle();
    compare("borrow_slice", 1'b1, 32'h0000_00FF, 1'b0);

    // Back-to-back throughput
    op(32'd10, 32'd1);
    op(32'h0001_0000, 32'h1);
    op(32'h8000_0000, 32'h8000_0000);
    compare("b2b_0", 1'b1, 32'd9, 1'b0);
    op(32'd1, 32'd2);
    compare("b2b_1", 1'b1, 32'h0000_FFFF, 1'b0);
    idle();
    compare("b2b_2", 1'b1, 32'h0, 1'b0);
    idle();
    compare("b2b_3", 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle();

    // Two-cycle stall delays completion by two cycles
    op(32'd100, 32'd58);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h2);
    compare("stall_hold", 1'b0, 32'h0, 1'b0);
    idle();
    compare("stall_t4", 1'b0, 32'h0, 1'b0);
    idle();
    compare("stall_done", 1'b1, 32'd42, 1'b0);

    // Flush beats stall and discards the request in the flush cycle
    op(32'd7, 32'd9);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 32'd1);
    compare("flush_clear", 1'b0, 32'h0, 1'b0);
    op(32'd50, 32'd8);
    compare("flush_t3", 1'b0, 32'h0, 1'b0);
    idle();
    compare("flush_t4", 1'b0, 32'h0, 1'b0);
    idle();
    compare("flush_new", 1'b1, 32'd42, 1'b0);

    // Reset with three operations in flight
    op(32'd20, 32'd3);
    op(32'd30, 32'd4);
    op(32'd40, 32'd50);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    compare("rst_flight0", 1'b0, 32'h0, 1'b0);
    idle();
    idle();
    idle();
    compare("rst_flight3", 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic r, f, s, q;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 4) == 0);
      q = ($urandom_range(0, 3) != 0);
      step(r, f, s, q, rand_operand(), rand_operand());
    end
    idle();
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
